// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use and long-op
// stalls, branch flushes, a one-entry long-op scoreboard and a stall-cycle counter.
module hazard_scoreboard #(
  parameter int unsigned RFIDX_W = 5,
  parameter int unsigned NSRC    = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NSRC*RFIDX_W-1:0]   i_id_rs,
  input  logic [NSRC-1:0]           i_id_rs_used,
  input  logic [RFIDX_W-1:0]        i_id_rd,
  input  logic                      i_id_rd_we,
  input  logic                      i_id_is_long,
  input  logic [NSRC*RFIDX_W-1:0]   i_ex_rs,
  input  logic [RFIDX_W-1:0]        i_ex_rd,
  input  logic                      i_ex_regwrite,
  input  logic                      i_ex_memtoreg,
  input  logic                      i_ex_is_long,
  input  logic                      i_ex_br_taken,
  input  logic [RFIDX_W-1:0]        i_mem_rd,
  input  logic [RFIDX_W-1:0]        i_wb_rd,
  input  logic                      i_mem_regwrite,
  input  logic                      i_wb_regwrite,
  input  logic                      i_lu_done,
  output logic [2*NSRC-1:0]         o_fwd_sel,
  output logic                      o_stall_f,
  output logic                      o_stall_d,
  output logic                      o_flush_d,
  output logic                      o_flush_e,
  output logic                      o_lu_busy,
  output logic [RFIDX_W-1:0]        o_lu_rd,
  output logic [CNT_W-1:0]          o_stall_cnt
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [RFIDX_W-1:0] r_lu_rd;
  logic [RFIDX_W-1:0] w_lu_rd_nxt;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic w_lu_busy;
  logic w_issue;
  logic w_match_ex;
  logic w_match_lu;
  logic w_load_use;
  logic w_ex_long_raw;
  logic w_lu_raw;
  logic w_lu_waw;
  logic w_lu_struct;
  logic w_hz;

  assign w_lu_busy = (r_state == S_BUSY);
  assign w_issue   = i_ex_is_long & i_ex_regwrite;

  // Does any live ID source read the EX destination or the outstanding long-op destination
  always_comb begin
    w_match_ex = 1'b0;
    w_match_lu = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (i_id_rs_used[i] && (i_id_rs[i*RFIDX_W +: RFIDX_W] == i_ex_rd)) w_match_ex = 1'b1;
      if (i_id_rs_used[i] && (i_id_rs[i*RFIDX_W +: RFIDX_W] == r_lu_rd)) w_match_lu = 1'b1;
    end
    w_match_ex = w_match_ex & (i_ex_rd != '0);
    w_match_lu = w_match_lu & (r_lu_rd != '0);
  end

  assign w_load_use    = i_ex_memtoreg & i_ex_regwrite & w_match_ex;
  assign w_ex_long_raw = i_ex_is_long & i_ex_regwrite & w_match_ex;
  assign w_lu_raw      = w_lu_busy & w_match_lu;
  assign w_lu_waw      = w_lu_busy & i_id_rd_we & (i_id_rd == r_lu_rd) & (r_lu_rd != '0);
  assign w_lu_struct   = i_id_is_long & (w_lu_busy | i_ex_is_long);
  assign w_hz          = w_load_use | w_ex_long_raw | w_lu_raw | w_lu_waw | w_lu_struct;

  // A taken branch squashes the ID instruction, so a flush overrides any stall
  always_comb begin
    o_stall_f = 1'b0;
    o_stall_d = 1'b0;
    o_flush_d = 1'b1;
    o_flush_e = 1'b1;
    if (i_rst_n) begin
      o_stall_f = w_hz & ~i_ex_br_taken;
      o_stall_d = w_hz & ~i_ex_br_taken;
      o_flush_d = i_ex_br_taken;
      o_flush_e = w_hz | i_ex_br_taken;
    end
  end

  // Per-source bypass select: MEM (10) has priority over WB (01)
  always_comb begin
    o_fwd_sel = '0;
    if (i_rst_n) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs[i*RFIDX_W +: RFIDX_W])) begin
          o_fwd_sel[2*i+1] = 1'b1;
        end else if (i_wb_regwrite && (i_wb_rd != '0) && (i_wb_rd == i_ex_rs[i*RFIDX_W +: RFIDX_W])) begin
          o_fwd_sel[2*i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_lu_rd <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lu_rd <= w_lu_rd_nxt;
    end
  end

  // A new issue takes precedence over a completion landing in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_lu_rd_nxt = r_lu_rd;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_state_nxt = S_BUSY;
          w_lu_rd_nxt = i_ex_rd;
        end
      end
      S_BUSY: begin
        if (w_issue) begin
          w_lu_rd_nxt = i_ex_rd;
        end else if (i_lu_done) begin
          w_state_nxt = S_IDLE;
          w_lu_rd_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_lu_rd_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (o_stall_d && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_lu_busy   = w_lu_busy;
  assign o_lu_rd     = r_lu_rd;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, hand-written multi-cycle sequences
// and random traffic, all compared against an abstract reference model.
module tb_hazard_scoreboard;

  localparam int unsigned RW   = 5;
  localparam int unsigned NSRC = 3;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  typedef struct {
    logic             rst_n;
    logic [NSRC*RW-1:0] id_rs;
    logic [NSRC-1:0]  id_rs_used;
    logic [RW-1:0]    id_rd;
    logic             id_rd_we;
    logic             id_is_long;
    logic [NSRC*RW-1:0] ex_rs;
    logic [RW-1:0]    ex_rd;
    logic             ex_regwrite;
    logic             ex_memtoreg;
    logic             ex_is_long;
    logic             ex_br_taken;
    logic [RW-1:0]    mem_rd;
    logic [RW-1:0]    wb_rd;
    logic             mem_regwrite;
    logic             wb_regwrite;
    logic             lu_done;
  } stim_t;

  typedef struct {
    stim_t             s;
    logic [2*NSRC-1:0] fwd;
    logic [3:0]        ctl;   // {stall_f, stall_d, flush_d, flush_e}
  } vec_t;

  logic clk;
  logic rst_n;
  logic [NSRC*RW-1:0] id_rs, ex_rs;
  logic [NSRC-1:0] id_rs_used;
  logic [RW-1:0] id_rd, ex_rd, mem_rd, wb_rd, lu_rd;
  logic id_rd_we, id_is_long, ex_regwrite, ex_memtoreg, ex_is_long, ex_br_taken;
  logic mem_regwrite, wb_regwrite, lu_done;
  logic [2*NSRC-1:0] fwd_sel;
  logic stall_f, stall_d, flush_d, flush_e, lu_busy;
  logic [CW-1:0] stall_cnt;

  hazard_scoreboard #(.RFIDX_W(RW), .NSRC(NSRC), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs(id_rs), .i_id_rs_used(id_rs_used), .i_id_rd(id_rd), .i_id_rd_we(id_rd_we),
    .i_id_is_long(id_is_long), .i_ex_rs(ex_rs), .i_ex_rd(ex_rd),
    .i_ex_regwrite(ex_regwrite), .i_ex_memtoreg(ex_memtoreg), .i_ex_is_long(ex_is_long),
    .i_ex_br_taken(ex_br_taken), .i_mem_rd(mem_rd), .i_wb_rd(wb_rd),
    .i_mem_regwrite(mem_regwrite), .i_wb_regwrite(wb_regwrite), .i_lu_done(lu_done),
    .o_fwd_sel(fwd_sel), .o_stall_f(stall_f), .o_stall_d(stall_d), .o_flush_d(flush_d),
    .o_flush_e(flush_e), .o_lu_busy(lu_busy), .o_lu_rd(lu_rd), .o_stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_chk = 0;
  int    n_fail = 0;
  stim_t cur;
  bit    m_init = 0;
  bit    m_busy = 0;
  int    m_rd = 0;
  int    m_cnt = 0;
  bit    m_stall = 0;
  vec_t  tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic stim_t base();
    stim_t s;
    s.rst_n = 1'b1;  s.id_rs = '0;  s.id_rs_used = '0;  s.id_rd = '0;
    s.id_rd_we = 1'b0;  s.id_is_long = 1'b0;  s.ex_rs = '0;  s.ex_rd = '0;
    s.ex_regwrite = 1'b0;  s.ex_memtoreg = 1'b0;  s.ex_is_long = 1'b0;
    s.ex_br_taken = 1'b0;  s.mem_rd = '0;  s.wb_rd = '0;  s.mem_regwrite = 1'b0;
    s.wb_regwrite = 1'b0;  s.lu_done = 1'b0;
    return s;
  endfunction

  // True when the ID instruction really reads architectural register r
  function automatic bit reads(input stim_t s, input int r);
    bit hit = 0;
    for (int i = 0; i < NSRC; i++)
      if (s.id_rs_used[i] && int'(s.id_rs[i*RW +: RW]) == r && r != 0) hit = 1;
    return hit;
  endfunction

  function automatic void model_comb(input stim_t s, input bit busy, input int lrd,
                                     output logic [2*NSRC-1:0] fwd, output logic [3:0] ctl);
    bit hz;
    int exd;
    fwd = '0;
    ctl = 4'b0011;
    if (s.rst_n) begin
      for (int i = 0; i < NSRC; i++) begin
        int src = int'(s.ex_rs[i*RW +: RW]);
        if (s.mem_regwrite && s.mem_rd != 0 && int'(s.mem_rd) == src) fwd[2*i+1] = 1'b1;
        else if (s.wb_regwrite && s.wb_rd != 0 && int'(s.wb_rd) == src) fwd[2*i] = 1'b1;
      end
      exd = int'(s.ex_rd);
      hz = (s.ex_regwrite && (s.ex_memtoreg || s.ex_is_long) && reads(s, exd))
         || (busy && reads(s, lrd))
         || (busy && s.id_rd_we && int'(s.id_rd) == lrd && lrd != 0)
         || (s.id_is_long && (busy || s.ex_is_long));
      if (s.ex_br_taken) ctl = 4'b0011;
      else if (hz)       ctl = 4'b1101;
      else               ctl = 4'b0000;
    end
  endfunction

  task automatic drive(input stim_t s);
    logic [2*NSRC-1:0] efwd;
    logic [3:0] ectl;
    @(negedge clk);
    cur = s;
    rst_n = s.rst_n;  id_rs = s.id_rs;  id_rs_used = s.id_rs_used;  id_rd = s.id_rd;
    id_rd_we = s.id_rd_we;  id_is_long = s.id_is_long;  ex_rs = s.ex_rs;  ex_rd = s.ex_rd;
    ex_regwrite = s.ex_regwrite;  ex_memtoreg = s.ex_memtoreg;  ex_is_long = s.ex_is_long;
    ex_br_taken = s.ex_br_taken;  mem_rd = s.mem_rd;  wb_rd = s.wb_rd;
    mem_regwrite = s.mem_regwrite;  wb_regwrite = s.wb_regwrite;  lu_done = s.lu_done;
    #1;
    model_comb(s, m_busy, m_rd, efwd, ectl);
    m_stall = ectl[2];
    chk("model_fwd", 32'(fwd_sel), 32'(efwd));
    chk("model_ctl", 32'({stall_f, stall_d, flush_d, flush_e}), 32'(ectl));
    if (m_init) begin
      chk("model_lu_busy", 32'(lu_busy), 32'(m_busy));
      chk("model_lu_rd", 32'(lu_rd), 32'(m_rd));
      chk("model_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!cur.rst_n) begin
      m_init = 1;  m_busy = 0;  m_rd = 0;  m_cnt = 0;
    end else begin
      if (m_stall && m_cnt < CMAX) m_cnt++;
      if (cur.ex_is_long && cur.ex_regwrite) begin
        m_busy = 1;  m_rd = int'(cur.ex_rd);
      end else if (cur.lu_done && m_busy) begin
        m_busy = 0;  m_rd = 0;
      end
    end
  endtask

  task automatic step(input stim_t s);
    drive(s);
    tick();
  endtask

  task automatic add(input stim_t s, input logic [2*NSRC-1:0] fwd, input logic [3:0] ctl);
    vec_t v;
    v.s = s;  v.fwd = fwd;  v.ctl = ctl;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    stim_t s = base();
    s.rst_n = 1'b0;
    step(s);
  endtask

  initial begin
    stim_t s;

    // Directed single-cycle vectors, scoreboard idle
    s = base(); s.mem_regwrite = 1; s.mem_rd = 5; s.wb_regwrite = 1; s.wb_rd = 5;
    s.ex_rs[0 +: RW] = 5;                                         add(s, 6'b000010, 4'b0000);
    s.mem_regwrite = 0;                                           add(s, 6'b000001, 4'b0000);
    s = base(); s.mem_regwrite = 1; s.wb_regwrite = 1;            add(s, 6'b000000, 4'b0000);
    s = base(); s.mem_regwrite = 1; s.mem_rd = 12; s.wb_regwrite = 1; s.wb_rd = 3;
    s.ex_rs[2*RW +: RW] = 12; s.ex_rs[RW +: RW] = 3;             add(s, 6'b100100, 4'b0000);
    s = base(); s.ex_rd = 7; s.ex_memtoreg = 1; s.ex_regwrite = 1;
    s.id_rs[RW +: RW] = 7; s.id_rs_used = 3'b010;                 add(s, 6'b000000, 4'b1101);
    s.id_rs_used = 3'b001;                                        add(s, 6'b000000, 4'b0000);
    s = base(); s.ex_memtoreg = 1; s.ex_regwrite = 1; s.id_rs_used = 3'b111;
                                                                  add(s, 6'b000000, 4'b0000);
    s = base(); s.ex_rd = 7; s.ex_memtoreg = 1; s.ex_regwrite = 1; s.ex_br_taken = 1;
    s.id_rs[2*RW +: RW] = 7; s.id_rs_used = 3'b100;               add(s, 6'b000000, 4'b0011);
    s = base(); s.ex_br_taken = 1;                                add(s, 6'b000000, 4'b0011);
    s = base(); s.ex_is_long = 1; s.id_is_long = 1;               add(s, 6'b000000, 4'b1101);
    s = base(); s.ex_is_long = 1; s.ex_rd = 4; s.id_rs[0 +: RW] = 4; s.id_rs_used = 3'b001;
                                                                  add(s, 6'b000000, 4'b0000);
    s = base(); s.rst_n = 0; s.ex_rd = 7; s.ex_memtoreg = 1; s.ex_regwrite = 1;
    s.id_rs[RW +: RW] = 7; s.id_rs_used = 3'b010; s.mem_regwrite = 1; s.mem_rd = 5;
    s.ex_rs[0 +: RW] = 5;                                         add(s, 6'b000000, 4'b0011);

    rst_n = 1'b0;
    do_reset();
    drive(base());
    chk("reset_lu_busy", 32'(lu_busy), 32'd0);
    chk("reset_lu_rd", 32'(lu_rd), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();

    foreach (tbl[k]) begin
      drive(tbl[k].s);
      chk($sformatf("tbl%0d_fwd", k), 32'(fwd_sel), 32'(tbl[k].fwd));
      chk($sformatf("tbl%0d_ctl", k), 32'({stall_f, stall_d, flush_d, flush_e}), 32'(tbl[k].ctl));
      tick();
    end

    // Load-use: one bubble, then WB bypass for the dependent
    do_reset();
    s = base(); s.ex_rd = 7; s.ex_memtoreg = 1; s.ex_regwrite = 1;
    s.id_rs[RW +: RW] = 7; s.id_rs_used = 3'b010;
    drive(s);
    chk("lduse_stall", 32'({stall_f, stall_d, flush_e}), 32'b111);
    tick();
    s = base(); s.mem_rd = 7; s.mem_regwrite = 1; s.id_rs[RW +: RW] = 7; s.id_rs_used = 3'b010;
    drive(s);
    chk("lduse_release", 32'(stall_d), 32'd0);
    chk("lduse_cnt", 32'(stall_cnt), 32'd1);
    tick();
    s = base(); s.wb_rd = 7; s.wb_regwrite = 1; s.ex_rs[RW +: RW] = 7;
    drive(s);
    chk("lduse_fwd_wb", 32'(fwd_sel[3:2]), 32'b01);
    tick();

    // Divide to x9 with a dependent waiting until the cycle after lu_done
    do_reset();
    s = base(); s.ex_is_long = 1; s.ex_regwrite = 1; s.ex_rd = 9;
    s.id_rs[0 +: RW] = 9; s.id_rs_used = 3'b001;
    drive(s);
    chk("div_c1_stall", 32'(stall_d), 32'd1);
    tick();
    for (int c = 2; c <= 6; c++) begin
      s = base(); s.id_rs[0 +: RW] = 9; s.id_rs_used = 3'b001; s.lu_done = (c == 6);
      drive(s);
      chk($sformatf("div_c%0d_stall", c), 32'(stall_d), 32'd1);
      chk($sformatf("div_c%0d_busy", c), 32'({lu_busy, lu_rd}), 32'({1'b1, 5'd9}));
      tick();
    end
    s = base(); s.id_rs[0 +: RW] = 9; s.id_rs_used = 3'b001;
    drive(s);
    chk("div_c7_stall", 32'(stall_d), 32'd0);
    chk("div_c7_busy", 32'(lu_busy), 32'd0);
    chk("div_c7_cnt", 32'(stall_cnt), 32'd6);
    tick();

    // WAW, structural, and x0 exemption while busy
    do_reset();
    s = base(); s.ex_is_long = 1; s.ex_regwrite = 1; s.ex_rd = 9; step(s);
    s = base(); s.id_rd = 9; s.id_rd_we = 1;
    drive(s); chk("waw_stall", 32'(stall_d), 32'd1); tick();
    s = base(); s.id_is_long = 1; s.id_rd = 3; s.id_rd_we = 1;
    drive(s); chk("struct_stall", 32'(stall_d), 32'd1); tick();
    s = base(); s.lu_done = 1; step(s);
    s = base(); s.ex_is_long = 1; s.ex_regwrite = 1; s.ex_rd = 0; step(s);
    s = base(); s.id_rs_used = 3'b111; s.id_rd_we = 1;
    drive(s);
    chk("x0_no_stall", 32'(stall_d), 32'd0);
    chk("x0_busy_rd", 32'({lu_busy, lu_rd}), 32'({1'b1, 5'd0}));
    tick();

    // Reset mid long-op, then a stray lu_done
    s = base(); s.ex_is_long = 1; s.ex_regwrite = 1; s.ex_rd = 9; step(s);
    do_reset();
    drive(base());
    chk("rst_mid_state", 32'({lu_busy, lu_rd, stall_cnt}), 32'd0);
    tick();
    s = base(); s.lu_done = 1; step(s);
    drive(base());
    chk("rst_stray_done", 32'(lu_busy), 32'd0);
    tick();

    // Counter saturation
    s = base(); s.ex_is_long = 1; s.id_is_long = 1;
    repeat (20) step(s);
    drive(base());
    chk("cnt_saturate", 32'(stall_cnt), 32'(CMAX));
    tick();

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      s = base();
      s.rst_n = ($urandom_range(0, 99) >= 3);
      for (int i = 0; i < NSRC; i++) begin
        s.id_rs[i*RW +: RW] = RW'($urandom_range(0, 7));
        s.ex_rs[i*RW +: RW] = RW'($urandom_range(0, 7));
      end
      s.id_rs_used   = NSRC'($urandom);
      s.id_rd        = RW'($urandom_range(0, 7));
      s.id_rd_we     = ($urandom_range(0, 1) == 1);
      s.id_is_long   = ($urandom_range(0, 9) == 0);
      s.ex_rd        = RW'($urandom_range(0, 7));
      s.ex_regwrite  = ($urandom_range(0, 2) != 0);
      s.ex_memtoreg  = ($urandom_range(0, 3) == 0);
      s.ex_is_long   = ($urandom_range(0, 6) == 0);
      s.ex_br_taken  = ($urandom_range(0, 9) == 0);
      s.mem_rd       = RW'($urandom_range(0, 7));
      s.wb_rd        = RW'($urandom_range(0, 7));
      s.mem_regwrite = ($urandom_range(0, 1) == 1);
      s.wb_regwrite  = ($urandom_range(0, 1) == 1);
      s.lu_done      = ($urandom_range(0, 3) == 0);
      step(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
